// File: rtl/vga_timing_ctrl.sv
// Free-running raster timing generator (XGA 1024x768@60 by default).
// All outputs are registered from next-state counter values so they stay mutually aligned.
module vga_timing_ctrl #(
    parameter int H_TOTAL      = 1344,
    parameter int V_TOTAL      = 806,
    parameter int H_ACTIVE     = 1024,
    parameter int V_ACTIVE     = 768,
    parameter int H_SYNC_START = 1048,
    parameter int H_SYNC_END   = 1184,
    parameter int V_SYNC_START = 771,
    parameter int V_SYNC_END   = 777,
    parameter int CNT_W        = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             frame_start,
    output logic             vblank_start
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_SYNC_END);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_SYNC_START);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_SYNC_END);

    if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_TOTAL))
    begin : g_bad_h_params
        $error("vga_timing_ctrl: horizontal timing parameters out of order");
    end
    if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_TOTAL))
    begin : g_bad_v_params
        $error("vga_timing_ctrl: vertical timing parameters out of order");
    end
    if ((2 ** CNT_W) < H_TOTAL || (2 ** CNT_W) < V_TOTAL) begin : g_bad_cnt_w
        $error("vga_timing_ctrl: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d;
    logic hblnk_q, hblnk_d, vblnk_q, vblnk_d;
    logic frame_start_q, frame_start_d;
    logic vblank_start_q, vblank_start_d;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
        // With en low the next state equals the current one, so levels hold naturally.
        hsync_d        = (hcount_d >= H_SS) && (hcount_d < H_SE);
        vsync_d        = (vcount_d >= V_SS) && (vcount_d < V_SE);
        hblnk_d        = (hcount_d >= H_ACT);
        vblnk_d        = (vcount_d >= V_ACT);
        // Pulses only on an actual wrap; a frozen position never re-fires them.
        frame_start_d  = en && (hcount_d == '0) && (vcount_d == '0);
        vblank_start_d = en && (hcount_d == '0) && (vcount_d == V_ACT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q       <= '0;
            vcount_q       <= '0;
            hsync_q        <= 1'b0;
            vsync_q        <= 1'b0;
            hblnk_q        <= 1'b0;
            vblnk_q        <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            hcount_q       <= hcount_d;
            vcount_q       <= vcount_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            hblnk_q        <= hblnk_d;
            vblnk_q        <= vblnk_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    assign hcount       = hcount_q;
    assign vcount       = vcount_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign hblnk        = hblnk_q;
    assign vblnk        = vblnk_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a shrunk-raster instance exercises full frames, a default XGA
// instance runs alongside; both are compared against a linear pixel-index reference model.
module tb_vga_timing_ctrl;

    localparam int S_HT = 40, S_VT = 20, S_HA = 24, S_VA = 14;
    localparam int S_HSS = 28, S_HSE = 32, S_VSS = 15, S_VSE = 17;
    localparam int S_FR = S_HT * S_VT;
    localparam int X_HT = 1344, X_VT = 806, X_HA = 1024, X_VA = 768;
    localparam int X_HSS = 1048, X_HSE = 1184, X_VSS = 771, X_VSE = 777;
    localparam int X_FR = X_HT * X_VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic [10:0] hc_s, vc_s, hc_x, vc_x;
    logic hs_s, vs_s, hb_s, vb_s, fs_s, vbs_s;
    logic hs_x, vs_x, hb_x, vb_x, fs_x, vbs_x;
    logic [55:0] obs;

    assign obs = {hc_s, vc_s, hs_s, vs_s, hb_s, vb_s, fs_s, vbs_s,
                  hc_x, vc_x, hs_x, vs_x, hb_x, vb_x, fs_x, vbs_x};

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .H_TOTAL(S_HT), .V_TOTAL(S_VT), .H_ACTIVE(S_HA), .V_ACTIVE(S_VA),
        .H_SYNC_START(S_HSS), .H_SYNC_END(S_HSE),
        .V_SYNC_START(S_VSS), .V_SYNC_END(S_VSE), .CNT_W(11)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en), .hcount(hc_s), .vcount(vc_s),
        .hsync(hs_s), .vsync(vs_s), .hblnk(hb_s), .vblnk(vb_s),
        .frame_start(fs_s), .vblank_start(vbs_s)
    );

    vga_timing_ctrl dut_x (
        .clk(clk), .rst(rst), .en(en), .hcount(hc_x), .vcount(vc_x),
        .hsync(hs_x), .vsync(vs_x), .hblnk(hb_x), .vblnk(vb_x),
        .frame_start(fs_x), .vblank_start(vbs_x)
    );

    // Reference model: raster position as a single index into the frame.
    int pos_s = 0, pos_x = 0;
    bit last_en = 1'b0;
    int checks = 0, errors = 0;

    function automatic logic [27:0] ev(int p, bit e, int ht, int ha, int hss, int hse,
                                       int va, int vss, int vse);
        int h, v;
        logic [10:0] hh, vv;
        h  = p % ht;
        v  = p / ht;
        hh = h[10:0];
        vv = v[10:0];
        return {hh, vv, (h >= hss && h < hse), (v >= vss && v < vse), (h >= ha), (v >= va),
                (e && p == 0), (e && p == va * ht)};
    endfunction

    function automatic logic [55:0] exp_all();
        return {ev(pos_s, last_en, S_HT, S_HA, S_HSS, S_HSE, S_VA, S_VSS, S_VSE),
                ev(pos_x, last_en, X_HT, X_HA, X_HSS, X_HSE, X_VA, X_VSS, X_VSE)};
    endfunction

    task automatic tick(input bit e);
        en = e;
        @(posedge clk);
        if (!rst && e) begin
            pos_s = (pos_s + 1) % S_FR;
            pos_x = (pos_x + 1) % X_FR;
        end
        last_en = e && !rst;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        #3;
        checks++;
        if (obs !== exp_all()) begin
            errors++;
            $display("FAIL reset_async: got %h exp %h", obs, exp_all());
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            checks++;
            if (obs !== exp_all()) begin
                errors++;
                $display("FAIL reset_hold: got %h exp %h", obs, exp_all());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_line();
        int hs_cnt = 0;
        for (int i = 0; i < X_HT; i++) begin
            tick(1'b1);
            if (hs_x) hs_cnt++;
            checks++;
            if (obs !== exp_all()) begin
                errors++;
                $display("FAIL line_cycle%0d: got %h exp %h", i, obs, exp_all());
            end
        end
        checks++;
        if (hc_x !== 11'd0 || vc_x !== 11'd1) begin
            errors++;
            $display("FAIL line_wrap: got (%0d,%0d) exp (0,1)", hc_x, vc_x);
        end
        checks++;
        if (hs_cnt != X_HSE - X_HSS) begin
            errors++;
            $display("FAIL line_hsync_len: got %0d exp %0d", hs_cnt, X_HSE - X_HSS);
        end
    endtask

    task automatic test_frame();
        int len = 0, vs_cnt = 0, vbs_cnt = 0, guard = 0;
        bit got = 1'b0;
        while (!fs_s && guard < 2 * S_FR) begin
            tick(1'b1);
            guard++;
        end
        checks++;
        if (!fs_s) begin
            errors++;
            $display("FAIL frame_first_pulse: got none exp pulse within %0d", 2 * S_FR);
        end
        while (!got && len < 2 * S_FR) begin
            tick(1'b1);
            len++;
            if (vs_s) vs_cnt++;
            if (vbs_s) begin
                vbs_cnt++;
                checks++;
                if (!vb_s || hc_s !== 11'd0 || vc_s !== 11'(S_VA)) begin
                    errors++;
                    $display("FAIL frame_vbs_pos: got (%0d,%0d,vb=%0b) exp (0,%0d,1)",
                             hc_s, vc_s, vb_s, S_VA);
                end
            end
            checks++;
            if (obs !== exp_all()) begin
                errors++;
                $display("FAIL frame_cycle%0d: got %h exp %h", len, obs, exp_all());
            end
            got = fs_s;
        end
        checks++;
        if (len != S_FR) begin
            errors++;
            $display("FAIL frame_len: got %0d exp %0d", len, S_FR);
        end
        checks++;
        if (vs_cnt != (S_VSE - S_VSS) * S_HT || vbs_cnt != 1) begin
            errors++;
            $display("FAIL frame_vsync_vbs: got %0d/%0d exp %0d/1",
                     vs_cnt, vbs_cnt, (S_VSE - S_VSS) * S_HT);
        end
    endtask

    task automatic test_hsync_gap();
        int len = 0;
        bit got = 1'b0;
        while (hc_s !== 11'(S_HSS - 1) && len < S_FR) begin
            tick(1'b1);
            len++;
        end
        for (int i = 0; i < 50; i++) begin
            tick(1'b0);
            len++;
            checks++;
            if (obs !== exp_all() || hs_s !== 1'b0 || hc_s !== 11'(S_HSS - 1)) begin
                errors++;
                $display("FAIL gap_hold%0d: got %h exp %h", i, obs, exp_all());
            end
        end
        tick(1'b1);
        len++;
        checks++;
        if (hs_s !== 1'b1 || hc_s !== 11'(S_HSS)) begin
            errors++;
            $display("FAIL gap_resume: got hs=%0b hc=%0d exp hs=1 hc=%0d", hs_s, hc_s, S_HSS);
        end
        while (!got && len < 2 * S_FR) begin
            tick(1'b1);
            len++;
            checks++;
            if (obs !== exp_all()) begin
                errors++;
                $display("FAIL gap_cycle%0d: got %h exp %h", len, obs, exp_all());
            end
            got = fs_s;
        end
        checks++;
        if (len != S_FR + 50) begin
            errors++;
            $display("FAIL gap_frame_len: got %0d exp %0d", len, S_FR + 50);
        end
    endtask

    task automatic test_fs_drop();
        int fs_cnt = 0;
        checks++;
        if (fs_s !== 1'b1) begin
            errors++;
            $display("FAIL fsdrop_pre: got fs=%0b exp 1", fs_s);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            checks++;
            if (fs_s !== 1'b0 || hc_s !== 11'd0 || vc_s !== 11'd0 || obs !== exp_all()) begin
                errors++;
                $display("FAIL fsdrop_hold%0d: got %h exp %h", i, obs, exp_all());
            end
        end
        for (int i = 0; i < S_FR - 1; i++) begin
            tick(1'b1);
            if (fs_s) fs_cnt++;
        end
        checks++;
        if (fs_cnt != 0) begin
            errors++;
            $display("FAIL fsdrop_repeat: got %0d pulses exp 0", fs_cnt);
        end
        tick(1'b1);
        checks++;
        if (fs_s !== 1'b1 || obs !== exp_all()) begin
            errors++;
            $display("FAIL fsdrop_next: got %h exp %h", obs, exp_all());
        end
    endtask

    task automatic test_async_rst();
        int len = 0, target;
        target = (S_VT / 2) * S_HT + S_HT / 2;
        while (pos_s != target && len < 2 * S_FR) begin
            tick(1'b1);
            len++;
        end
        #2;
        rst = 1'b1;
        #1;
        pos_s = 0;
        pos_x = 0;
        last_en = 1'b0;
        checks++;
        if (obs !== exp_all()) begin
            errors++;
            $display("FAIL arst_immediate: got %h exp %h", obs, exp_all());
        end
        tick(1'b1);
        tick(1'b1);
        rst = 1'b0;
        tick(1'b1);
        checks++;
        if (hc_s !== 11'd1 || vc_s !== 11'd0 || obs !== exp_all()) begin
            errors++;
            $display("FAIL arst_restart: got %h exp %h", obs, exp_all());
        end
        // Counted from the (1,0) cycle onward.
        len = 0;
        while (!fs_s && len < 2 * S_FR) begin
            tick(1'b1);
            len++;
        end
        checks++;
        if (len != S_FR - 1) begin
            errors++;
            $display("FAIL arst_frame_len: got %0d exp %0d", len, S_FR - 1);
        end
    endtask

    task automatic test_random();
        int enabled = 0, iter = 0;
        bit e;
        while (enabled < 3 * S_FR && iter < 12 * S_FR) begin
            e = ($urandom_range(0, 3) != 0);
            tick(e);
            iter++;
            if (e) enabled++;
            checks++;
            if (obs !== exp_all() || hb_s !== (hc_s >= 11'(S_HA)) || vb_s !== (vc_s >= 11'(S_VA))) begin
                errors++;
                $display("FAIL rand_cycle%0d: got %h exp %h", iter, obs, exp_all());
            end
        end
        checks++;
        if (enabled < 3 * S_FR) begin
            errors++;
            $display("FAIL rand_budget: got %0d enabled exp %0d", enabled, 3 * S_FR);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_hsync_gap();
        test_fs_drop();
        test_async_rst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
